// File: rtl/alu_regfile.sv
// Register file with a three-state issue/write-back sequencer feeding an external ALU.
// Optional macro ALU_REGFILE_BYPASS_EN: accept a new start during write-back, forwarding wb_data.
module alu_regfile #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3+3*ADDR_W-1:0] instr,
  output logic [DATA_W-1:0]     data_a,
  output logic [DATA_W-1:0]     data_b,
  output logic                  op_valid,
  input  logic                  wb_valid,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic                op_valid_q, op_valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [2:0]          opcode;
  logic [ADDR_W-1:0]   dst_f, src_a_f, src_b_f;
  logic                accept, fwd, we;
  logic [DATA_W-1:0]   rd_a, rd_b;

  assign opcode  = instr[3+3*ADDR_W-1 -: 3];
  assign dst_f   = instr[3*ADDR_W-1 -: ADDR_W];
  assign src_a_f = instr[2*ADDR_W-1 -: ADDR_W];
  assign src_b_f = instr[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    dst_d      = dst_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    accept     = 1'b0;
    fwd        = 1'b0;
    we         = 1'b0;
    rd_a       = '0;
    rd_b       = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_WB;
      WAIT_WB: begin
        if (wb_valid) begin
          we      = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef ALU_REGFILE_BYPASS_EN
          if (start) begin
            accept  = 1'b1;
            fwd     = 1'b1;
            state_d = ISSUE;
          end
`else
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (wb_valid && state_q != WAIT_WB) err_d = 1'b1;

    if (accept) begin
      dst_d      = dst_f;
      op_valid_d = 1'b1;
      // mem_q still holds the old value at the write edge, so same-index reads take wb_data
      rd_a = (fwd && src_a_f == dst_q) ? wb_data : mem_q[src_a_f];
      rd_b = (fwd && src_b_f == dst_q) ? wb_data : mem_q[src_b_f];
      data_a_d = (opcode != 3'd6) ? rd_a : '0;
      data_b_d = (opcode == 3'd0 || opcode == 3'd4 || opcode == 3'd5) ? rd_b : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dst_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_valid_q <= op_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (we) mem_q[dst_q] <= wb_data;
    end
  end

  assign data_a   = data_a_q;
  assign data_b   = data_b_q;
  assign op_valid = op_valid_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile (DATA_W=4, ADDR_W=1); instr = {op[2:0], dst, src_a, src_b}.
module tb_alu_regfile;

  logic       clk = 1'b0;
  logic       reset, start, wb_valid;
  logic [5:0] instr;
  logic [3:0] wb_data, data_a, data_b;
  logic       op_valid, done, busy, err;

  int n_checks = 0;
  int n_pass   = 0;

  alu_regfile #(.DATA_W(4), .ADDR_W(1)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .data_a(data_a), .data_b(data_b), .op_valid(op_valid),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] mk(input int op, input int d, input int a, input int b);
    mk = {op[2:0], d[0], a[0], b[0]};
  endfunction

  // Issue, advance to WAIT_WB, write wb value back, return to IDLE.
  task automatic run_op(input logic [5:0] ins, input logic [3:0] wbv);
    instr = ins; start = 1'b1; tick(); start = 1'b0;
    tick();
    wb_valid = 1'b1; wb_data = wbv; tick(); wb_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wb_valid = 1'b0; wb_data = '0; instr = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_data_a", data_a, 0);
    check("rst_data_b", data_b, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);

    // Opcode 0, dst=1, a=0, b=1 on cleared memory
    instr = mk(0, 1, 0, 1); start = 1'b1; tick(); start = 1'b0;
    check("issue_op_valid", op_valid, 1);
    check("issue_data_a", data_a, 0);
    check("issue_data_b", data_b, 0);
    check("issue_busy", busy, 1);
    tick();
    check("op_valid_pulse", op_valid, 0);
    tick(); tick();
    check("wait_busy", busy, 1);
    check("wait_done", done, 0);
    wb_valid = 1'b1; wb_data = 4'hA; tick(); wb_valid = 1'b0;
    check("wb_done", done, 1);
    check("wb_busy", busy, 0);
    tick();
    check("done_pulse", done, 0);

    // Opcode 4 reads mem[1]=A, mem[0]=0
    instr = mk(4, 0, 1, 0); start = 1'b1; tick(); start = 1'b0;
    check("op4_data_a", data_a, 4'hA);
    check("op4_data_b", data_b, 0);
    tick();
    wb_valid = 1'b1; wb_data = 4'h3; tick(); wb_valid = 1'b0; tick();

    // Opcode 6: neither operand used
    instr = mk(6, 0, 1, 1); start = 1'b1; tick(); start = 1'b0;
    check("op6_data_a", data_a, 0);
    check("op6_data_b", data_b, 0);
    tick();
    wb_valid = 1'b1; wb_data = 4'h7; tick(); wb_valid = 1'b0; tick();

    // Opcode 1: only src_a; mem0=7 mem1=A
    instr = mk(1, 1, 1, 0); start = 1'b1; tick(); start = 1'b0;
    check("op1_data_a", data_a, 4'hA);
    check("op1_data_b", data_b, 0);
    tick();
    wb_valid = 1'b1; wb_data = 4'hF; tick(); wb_valid = 1'b0; tick();

    // Opcode 5 both operands; start in ISSUE/WAIT_WB must be ignored
    instr = mk(5, 0, 0, 1); start = 1'b1; tick();
    check("op5_data_a", data_a, 4'h7);
    check("op5_data_b", data_b, 4'hF);
    instr = mk(0, 1, 1, 1); tick();
    check("ign_start_op_valid", op_valid, 0);
    check("ign_start_data_a", data_a, 4'h7);
    check("ign_start_data_b", data_b, 4'hF);
    tick();
    check("ign_start_op_valid2", op_valid, 0);
    check("ign_start_err", err, 0);
    start = 1'b0;
    wb_valid = 1'b1; wb_data = 4'h7; tick(); wb_valid = 1'b0; tick();

    // Write-back strobe in IDLE: sets err, does not write mem[dst]
    instr = mk(0, 1, 0, 0);
    wb_valid = 1'b1; wb_data = 4'h0; tick(); wb_valid = 1'b0;
    check("idle_wb_err", err, 1);
    check("idle_wb_busy", busy, 0);
    tick(); tick();
    check("err_sticky", err, 1);
    instr = mk(0, 0, 1, 0); start = 1'b1; tick(); start = 1'b0;
    check("mem_kept_a", data_a, 4'hF);
    check("mem_kept_b", data_b, 4'h7);
    tick();
    wb_valid = 1'b1; wb_data = 4'h7; tick(); wb_valid = 1'b0; tick();

    // Write-back to dst=1 with simultaneous start reading index 1
    instr = mk(0, 1, 0, 1); start = 1'b1; tick(); start = 1'b0;
    tick();
    instr = mk(0, 0, 1, 1); start = 1'b1; wb_valid = 1'b1; wb_data = 4'h5;
    tick(); start = 1'b0; wb_valid = 1'b0;
    check("bypass_done", done, 1);
`ifdef ALU_REGFILE_BYPASS_EN
    check("bypass_op_valid", op_valid, 1);
    check("bypass_data_a", data_a, 4'h5);
    check("bypass_data_b", data_b, 4'h5);
    check("bypass_busy", busy, 1);
    tick();
    wb_valid = 1'b1; wb_data = 4'h2; tick(); wb_valid = 1'b0; tick();
`else
    check("nobypass_op_valid", op_valid, 0);
    check("nobypass_busy", busy, 0);
    tick();
    instr = mk(0, 0, 1, 0); start = 1'b1; tick(); start = 1'b0;
    check("nobypass_read_a", data_a, 4'h5);
    check("nobypass_read_b", data_b, 4'h7);
    tick();
    wb_valid = 1'b1; wb_data = 4'h2; tick(); wb_valid = 1'b0; tick();
`endif

    // Reset in WAIT_WB with write pending
    instr = mk(0, 1, 0, 1); start = 1'b1; tick(); start = 1'b0;
    tick();
    check("pre_rst_busy", busy, 1);
    reset = 1'b1; wb_valid = 1'b1; wb_data = 4'h9; tick();
    reset = 1'b0; wb_valid = 1'b0;
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_data_a", data_a, 0);
    tick();
    check("post_rst_done", done, 0);
    instr = mk(0, 0, 0, 1); start = 1'b1; tick(); start = 1'b0;
    check("rst_mem0", data_a, 0);
    check("rst_mem1", data_b, 0);
    tick();
    wb_valid = 1'b1; wb_data = 4'h1; tick(); wb_valid = 1'b0; tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
